reg_pipeline: RTL
=================

# reg_pipeline

Parametrised, elastic register pipeline generalising the single-bit synchronous-reset flip-flop into a WIDTH-bit, DEPTH-stage delay line with per-stage valid bits, valid/ready flow control, bubble collapsing and flush. It sits between producer and consumer blocks that need fixed pipeline delay plus back-pressure, for example to register long routes or align datapaths with a multi-cycle unit.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1)
- RESET_VAL, 0, value loaded into every data register on reset
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer offers in_data
- in_data  input  WIDTH  producer data
- in_ready  output  1  pipeline accepts in_data this cycle
- out_valid  output  1  out_data is valid
- out_data  output  WIDTH  consumer data
- out_ready  input  1  consumer accepts out_data this cycle
- flush  input  1  discard all in-flight entries
- count  output  $clog2(DEPTH+1)  number of valid stages

## Operation
- Stage i holds v[i], d[i]; stage 0 is input side, stage DEPTH-1 drives out_valid/out_data directly.
- Ready chain: rdy[DEPTH-1] = !v[DEPTH-1] | out_ready; rdy[i] = !v[i] | rdy[i+1]; in_ready = rdy[0].
- When rdy[i]=1, stage i loads from upstream (stage i-1, or in_valid/in_data for stage 0): v[i] <= upstream valid; d[i] <= upstream data only if upstream valid=1, otherwise d[i] holds.
- When rdy[i]=0, stage i holds v and d.
- Bubbles collapse: an empty stage always accepts, even under downstream stall.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- flush=1: all v[i] <= 0 next edge; any input transfer that cycle is discarded; data registers are not cleared; in_ready is still computed normally. Outputs in the flush cycle are valid and an output transfer in that cycle counts as completed.
- count <= popcount of next-state v; reflects the stages currently occupied.
- Priority: rst > flush > normal operation.
- Reset: all v[i]=0, all d[i]=RESET_VAL, count=0, so out_valid=0, out_data=RESET_VAL, and in_ready=1 from the first cycle after reset.
- Reset mid-operation: all in-flight entries are lost and no out_valid pulse follows.
- DEPTH=1: single stage; in_ready = !v[0] | out_ready.

## Timing
- Latency: item accepted at edge N appears on out_valid after edge N+DEPTH-1 (visible in cycle N+DEPTH) if no stall; minimum latency DEPTH cycles, independent of occupancy once flowing.
- Throughput: 1 item/cycle with out_ready held high.
- Full: count=DEPTH with out_ready=0 forces in_ready=0. Simultaneous pop and push when full is allowed; count stays DEPTH.
- in_ready depends combinationally on out_ready through a DEPTH-long OR chain. No other combinational input-to-output path exists; out_valid, out_data and count are registered.
- Data order is strictly preserved; no item is duplicated or dropped except by flush or rst.

## Structure
- Shared package: the count-width function (clog2(DEPTH+1)) and the default RESET_VAL constant.
- One natural sub-module: pipe_stage, a single valid+data register with load enable (rdy), synchronous rst to {0, RESET_VAL} and flush clearing valid. reg_pipeline instantiates DEPTH copies with a generate loop and builds the ready chain and popcount.

## Test plan
- Streaming: WIDTH=8, DEPTH=4, out_ready=1, push 0x01..0x10 back-to-back -> 0x01 on out first in cycle 4 after accept, then one item/cycle in order, in_ready never 0.
- Fill and stall: out_ready=0, push 0xA0..0xA5 -> first 4 accepted, in_ready=0 afterwards, count=4; raise out_ready -> 0xA0..0xA3 emerge, then 0xA4, 0xA5 accepted.
- Bubble collapse: push 0x11, idle 2 cycles, push 0x22, out_ready=0 -> both compact to stages 3 and 2, count=2; out_ready=1 yields 0x11 then 0x22 on consecutive cycles.
- Flush: count=3 with in_valid=1 and in_data=0x55 during flush -> next cycle count=0, out_valid=0, 0x55 never appears.
- Reset mid-stream: rst for 1 cycle with count=4 -> out_valid=0, out_data=RESET_VAL, count=0, in_ready=1; stream resumes without stale data.
- DEPTH=1 corner: simultaneous pop and push every cycle -> throughput 1/cycle, latency 1 cycle.

Source files
------------

// File: rtl/reg_pipeline_pkg.sv
// rtl/reg_pipeline_pkg.sv - shared constants and helpers for the elastic register pipeline
package reg_pipeline_pkg;

    localparam int unsigned DEFAULT_RESET_VAL = 0;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipeline_pipe_stage.sv
// rtl/reg_pipeline_pipe_stage.sv - one valid+data register slot of the elastic pipeline
module pipe_stage
    import reg_pipeline_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             valid_next
);

    always_comb begin
        valid_next = valid;
        if (flush) begin
            valid_next = 1'b0;
        end else if (load) begin
            valid_next = up_valid;
        end
    end

    // Data only moves with a valid upstream entry, so a bubble never overwrites it.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else begin
            valid <= valid_next;
            if (!flush && load && up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/reg_pipeline.sv
// rtl/reg_pipeline.sv - WIDTH x DEPTH elastic register pipeline with bubble collapse and flush
module reg_pipeline
    import reg_pipeline_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           in_ready,
    output logic                           out_valid,
    output logic [WIDTH-1:0]               out_data,
    input  logic                           out_ready,
    input  logic                           flush,
    output logic [count_width(DEPTH)-1:0]  count
);

    localparam int CW = count_width(DEPTH);

    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_next;
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] d    [DEPTH];
    logic [WIDTH-1:0] up_d [DEPTH];
    logic [CW-1:0]    cnt_next;

    assign rdy[DEPTH] = out_ready;

    // A stage is ready when empty or when everything downstream can move.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        assign rdy[i] = !v[i] | rdy[i+1];

        if (i == 0) begin : g_head
            assign up_v[i] = in_valid;
            assign up_d[i] = in_data;
        end else begin : g_body
            assign up_v[i] = v[i-1];
            assign up_d[i] = d[i-1];
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .load       (rdy[i]),
            .up_valid   (up_v[i]),
            .up_data    (up_d[i]),
            .valid      (v[i]),
            .data       (d[i]),
            .valid_next (v_next[i])
        );
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_next = cnt_next + CW'(v_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= cnt_next;
        end
    end

endmodule
